channel_centroid: RTL



---
 rtl/channel_centroid.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/channel_centroid.sv
// Window threshold on the selected channel, per-frame accumulation of in-window
// pixel coordinates, and a sequential restoring divider producing the centroid.
module channel_centroid #(
    parameter int unsigned HRES = 1280,
    parameter int unsigned VRES = 720,
    localparam int unsigned XW = $clog2(HRES),
    localparam int unsigned YW = $clog2(VRES)
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic [7:0]    channel_in,
    input  logic [7:0]    lower_in,
    input  logic [7:0]    upper_in,
    input  logic [XW-1:0] x_in,
    input  logic [YW-1:0] y_in,
    input  logic          valid_in,
    input  logic          frame_done_in,
    output logic          mask_out,
    output logic          mask_valid_out,
    output logic [XW-1:0] x_out,
    output logic [YW-1:0] y_out,
    output logic          valid_out,
    output logic          busy_out
);

    localparam int unsigned SW = 32;
    localparam int unsigned CW = 21;
    localparam int unsigned IW = 5;
    localparam logic [IW-1:0] LAST_STEP = IW'(SW - 1);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  sum_x_q, sum_y_q;
    logic [CW-1:0]  count_q;
    logic [SW-1:0]  quo_x_q, quo_y_q, rem_x_q, rem_y_q;
    logic [CW-1:0]  div_cnt_q;
    logic [IW-1:0]  step_q;

    logic           hit_c;
    logic [SW-1:0]  close_x_c, close_y_c;
    logic [CW-1:0]  close_cnt_c;
    logic           load_c, iter_c, finish_c;
    logic [SW:0]    step_x_c, step_y_c;

    // One restoring step: {quotient bit, new remainder}
    function automatic logic [SW:0] div_step(input logic [SW-1:0] rem,
                                             input logic          nb,
                                             input logic [CW-1:0] d);
        logic [SW:0] trial;
        trial = {rem, nb};
        if (trial >= (SW+1)'(d))
            return {1'b1, SW'(trial - (SW+1)'(d))};
        else
            return {1'b0, trial[SW-1:0]};
    endfunction

    assign hit_c = valid_in && (channel_in >= lower_in) && (channel_in <= upper_in);

    // A pixel coincident with frame_done belongs to the closing frame
    assign close_x_c   = sum_x_q + (hit_c ? SW'(x_in) : SW'(0));
    assign close_y_c   = sum_y_q + (hit_c ? SW'(y_in) : SW'(0));
    assign close_cnt_c = count_q + CW'(hit_c);

    assign step_x_c = div_step(rem_x_q, quo_x_q[SW-1], div_cnt_q);
    assign step_y_c = div_step(rem_y_q, quo_y_q[SW-1], div_cnt_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= ACCUM;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        iter_c   = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            ACCUM: begin
                if (frame_done_in && (close_cnt_c != '0)) begin
                    load_c  = 1'b1;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                iter_c = 1'b1;
                if (step_q == LAST_STEP) state_d = DONE;
            end
            DONE: begin
                finish_c = 1'b1;
                state_d  = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    // Accumulators run in every state; frame_done always starts a fresh frame
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            count_q <= '0;
        end else if (frame_done_in) begin
            sum_x_q <= '0;
            sum_y_q <= '0;
            count_q <= '0;
        end else if (hit_c) begin
            sum_x_q <= sum_x_q + SW'(x_in);
            sum_y_q <= sum_y_q + SW'(y_in);
            count_q <= count_q + CW'(1);
        end
    end

    // Dividend shifts out of quo_* MSB first while quotient bits shift in
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            quo_x_q   <= '0;
            quo_y_q   <= '0;
            rem_x_q   <= '0;
            rem_y_q   <= '0;
            div_cnt_q <= '0;
            step_q    <= '0;
        end else if (load_c) begin
            quo_x_q   <= close_x_c;
            quo_y_q   <= close_y_c;
            rem_x_q   <= '0;
            rem_y_q   <= '0;
            div_cnt_q <= close_cnt_c;
            step_q    <= '0;
        end else if (iter_c) begin
            quo_x_q <= {quo_x_q[SW-2:0], step_x_c[SW]};
            quo_y_q <= {quo_y_q[SW-2:0], step_y_c[SW]};
            rem_x_q <= step_x_c[SW-1:0];
            rem_y_q <= step_y_c[SW-1:0];
            step_q  <= step_q + IW'(1);
        end
    end

    // busy covers the cycle after DONE so the result pulse is inside it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mask_out       <= 1'b0;
            mask_valid_out <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            valid_out      <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            mask_out       <= hit_c;
            mask_valid_out <= valid_in;
            valid_out      <= finish_c;
            busy_out       <= (state_d != ACCUM) || (state_q == DONE);
            if (finish_c) begin
                x_out <= quo_x_q[XW-1:0];
                y_out <= quo_y_q[YW-1:0];
            end
        end
    end

endmodule
